// File: rtl/regfile_rename_mp_pkg.sv
// Shared front-end constants: datapath widths and per-cycle port counts
// used by the register file, decoder and ROB.
package regfile_rename_mp_pkg;

   localparam int DEF_XLEN    = 32;
   localparam int DEF_NREG    = 32;
   localparam int DEF_REG_BIT = 5;
   localparam int DEF_ROB_BIT = 4;
   localparam int DEF_NUM_RD  = 4;
   localparam int DEF_NUM_REN = 2;
   localparam int DEF_NUM_CMT = 2;

endpackage

// File: rtl/regfile_lookup.sv
// One combinational operand lookup port with same-cycle commit bypass.
module regfile_lookup
   import regfile_rename_mp_pkg::*;
#(
   parameter int XLEN    = DEF_XLEN,
   parameter int REG_BIT = DEF_REG_BIT,
   parameter int ROB_BIT = DEF_ROB_BIT,
   parameter int NUM_CMT = DEF_NUM_CMT
) (
   input  logic [REG_BIT-1:0]         rd_reg,
   input  logic                       ent_busy,
   input  logic [ROB_BIT-1:0]         ent_tag,
   input  logic [XLEN-1:0]            ent_val,
   input  logic [NUM_CMT-1:0]         cmt_en,
   input  logic [NUM_CMT*REG_BIT-1:0] cmt_reg,
   input  logic [NUM_CMT*ROB_BIT-1:0] cmt_tag,
   input  logic [NUM_CMT*XLEN-1:0]    cmt_val,
   output logic                       rd_busy,
   output logic [XLEN-1:0]            rd_val,
   output logic [ROB_BIT-1:0]         rd_tag
);

   logic            byp_hit;
   logic [XLEN-1:0] byp_val;

   // Ascending scan so the youngest matching commit slot is the one kept.
   always_comb begin
      byp_hit = 1'b0;
      byp_val = '0;
      for (int k = 0; k < NUM_CMT; k++) begin
         if (cmt_en[k] && cmt_reg[k*REG_BIT +: REG_BIT] == rd_reg &&
             cmt_tag[k*ROB_BIT +: ROB_BIT] == ent_tag) begin
            byp_hit = 1'b1;
            byp_val = cmt_val[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rd_busy = 1'b0;
      rd_val  = '0;
      rd_tag  = '0;
      if (rd_reg == '0) begin
         rd_busy = 1'b0;
      end else if (ent_busy && byp_hit) begin
         rd_val = byp_val;
      end else if (ent_busy) begin
         rd_busy = 1'b1;
         rd_tag  = ent_tag;
      end else begin
         rd_val = ent_val;
      end
   end

endmodule

// File: rtl/regfile_rename_mp.sv
// Architectural register file with busy/tag rename tracking, multi-port
// lookups, in-order commits and mispredict flush.
module regfile_rename_mp
   import regfile_rename_mp_pkg::*;
#(
   parameter int XLEN    = DEF_XLEN,
   parameter int NREG    = DEF_NREG,
   parameter int REG_BIT = DEF_REG_BIT,
   parameter int ROB_BIT = DEF_ROB_BIT,
   parameter int NUM_RD  = DEF_NUM_RD,
   parameter int NUM_REN = DEF_NUM_REN,
   parameter int NUM_CMT = DEF_NUM_CMT
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       flush_in,
   input  logic [NUM_REN-1:0]         ren_en,
   input  logic [NUM_REN*REG_BIT-1:0] ren_reg,
   input  logic [NUM_REN*ROB_BIT-1:0] ren_tag,
   input  logic [NUM_CMT-1:0]         cmt_en,
   input  logic [NUM_CMT*REG_BIT-1:0] cmt_reg,
   input  logic [NUM_CMT*ROB_BIT-1:0] cmt_tag,
   input  logic [NUM_CMT*XLEN-1:0]    cmt_val,
   input  logic [NUM_RD*REG_BIT-1:0]  rd_reg,
   output logic [NUM_RD-1:0]          rd_busy,
   output logic [NUM_RD*XLEN-1:0]     rd_val,
   output logic [NUM_RD*ROB_BIT-1:0]  rd_tag
);

   logic [XLEN-1:0]    regs_q [NREG];
   logic [XLEN-1:0]    regs_d [NREG];
   logic [ROB_BIT-1:0] tag_q  [NREG];
   logic [ROB_BIT-1:0] tag_d  [NREG];
   logic [NREG-1:0]    busy_q;
   logic [NREG-1:0]    busy_d;

   // Later assignments override earlier ones, giving commit < rename < flush.
   always_comb begin
      regs_d = regs_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (rdy_in) begin
         for (int k = 0; k < NUM_CMT; k++) begin
            if (cmt_en[k] && cmt_reg[k*REG_BIT +: REG_BIT] != '0) begin
               regs_d[cmt_reg[k*REG_BIT +: REG_BIT]] = cmt_val[k*XLEN +: XLEN];
               if (tag_q[cmt_reg[k*REG_BIT +: REG_BIT]] == cmt_tag[k*ROB_BIT +: ROB_BIT])
                  busy_d[cmt_reg[k*REG_BIT +: REG_BIT]] = 1'b0;
            end
         end
         if (flush_in) begin
            busy_d = '0;
         end else begin
            for (int j = 0; j < NUM_REN; j++) begin
               if (ren_en[j] && ren_reg[j*REG_BIT +: REG_BIT] != '0) begin
                  busy_d[ren_reg[j*REG_BIT +: REG_BIT]] = 1'b1;
                  tag_d[ren_reg[j*REG_BIT +: REG_BIT]]  = ren_tag[j*ROB_BIT +: ROB_BIT];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         busy_q <= busy_d;
         regs_q <= regs_d;
         tag_q  <= tag_d;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_lookup #(
         .XLEN    (XLEN),
         .REG_BIT (REG_BIT),
         .ROB_BIT (ROB_BIT),
         .NUM_CMT (NUM_CMT)
      ) u_lookup (
         .rd_reg   (rd_reg[p*REG_BIT +: REG_BIT]),
         .ent_busy (busy_q[rd_reg[p*REG_BIT +: REG_BIT]]),
         .ent_tag  (tag_q[rd_reg[p*REG_BIT +: REG_BIT]]),
         .ent_val  (regs_q[rd_reg[p*REG_BIT +: REG_BIT]]),
         .cmt_en   (cmt_en),
         .cmt_reg  (cmt_reg),
         .cmt_tag  (cmt_tag),
         .cmt_val  (cmt_val),
         .rd_busy  (rd_busy[p]),
         .rd_val   (rd_val[p*XLEN +: XLEN]),
         .rd_tag   (rd_tag[p*ROB_BIT +: ROB_BIT])
      );
   end

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Directed self-checking bench for regfile_rename_mp.
module tb_regfile_rename_mp;

   localparam int XLEN = 32;
   localparam int RB   = 5;
   localparam int TB   = 4;
   localparam int NRD  = 4;
   localparam int NREN = 2;
   localparam int NCMT = 2;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                rdy_in;
   logic                flush_in;
   logic [NREN-1:0]     ren_en;
   logic [NREN*RB-1:0]  ren_reg;
   logic [NREN*TB-1:0]  ren_tag;
   logic [NCMT-1:0]     cmt_en;
   logic [NCMT*RB-1:0]  cmt_reg;
   logic [NCMT*TB-1:0]  cmt_tag;
   logic [NCMT*XLEN-1:0] cmt_val;
   logic [NRD*RB-1:0]   rd_reg;
   logic [NRD-1:0]      rd_busy;
   logic [NRD*XLEN-1:0] rd_val;
   logic [NRD*TB-1:0]   rd_tag;

   int checks = 0;
   int errors = 0;

   regfile_rename_mp dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .ren_en   (ren_en),
      .ren_reg  (ren_reg),
      .ren_tag  (ren_tag),
      .cmt_en   (cmt_en),
      .cmt_reg  (cmt_reg),
      .cmt_tag  (cmt_tag),
      .cmt_val  (cmt_val),
      .rd_reg   (rd_reg),
      .rd_busy  (rd_busy),
      .rd_val   (rd_val),
      .rd_tag   (rd_tag)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      ren_en   = '0;
      ren_reg  = '0;
      ren_tag  = '0;
      cmt_en   = '0;
      cmt_reg  = '0;
      cmt_tag  = '0;
      cmt_val  = '0;
   endtask

   task automatic setRen(input int slot, input logic [RB-1:0] r, input logic [TB-1:0] t);
      ren_en[slot]             = 1'b1;
      ren_reg[slot*RB +: RB]   = r;
      ren_tag[slot*TB +: TB]   = t;
   endtask

   task automatic setCmt(input int slot, input logic [RB-1:0] r, input logic [TB-1:0] t,
                         input logic [XLEN-1:0] v);
      cmt_en[slot]               = 1'b1;
      cmt_reg[slot*RB +: RB]     = r;
      cmt_tag[slot*TB +: TB]     = t;
      cmt_val[slot*XLEN +: XLEN] = v;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      applyStimulus();
   endtask

   task automatic checkPort(input string name, input int p, input logic [RB-1:0] r,
                            input logic b, input logic [XLEN-1:0] v, input logic [TB-1:0] t);
      rd_reg[p*RB +: RB] = r;
      #1;
      checkOutput({name, ".busy"}, 32'(rd_busy[p]), 32'(b));
      checkOutput({name, ".val"}, rd_val[p*XLEN +: XLEN], v);
      checkOutput({name, ".tag"}, 32'(rd_tag[p*TB +: TB]), 32'(t));
   endtask

   initial begin
      applyStimulus();
      rd_reg = '0;
      rst_in = 1'b1;
      #12;
      checkPort("reset_x5", 0, 5'd5, 1'b0, 32'h0, 4'd0);
      rst_in = 1'b0;
      tick();

      // rename, lookup, bypass, then storage
      setRen(0, 5'd3, 4'd7);
      tick();
      checkPort("ren_x3", 1, 5'd3, 1'b1, 32'h0, 4'd7);
      setCmt(0, 5'd3, 4'd7, 32'hDEAD);
      checkPort("byp_x3", 2, 5'd3, 1'b0, 32'hDEAD, 4'd0);
      tick();
      checkPort("stor_x3", 3, 5'd3, 1'b0, 32'hDEAD, 4'd0);

      // stale-tag commit keeps younger producer busy
      setRen(0, 5'd4, 4'd2);
      tick();
      setRen(1, 5'd4, 4'd5);
      tick();
      setCmt(0, 5'd4, 4'd2, 32'h11);
      checkPort("stale_byp_x4", 0, 5'd4, 1'b1, 32'h0, 4'd5);
      tick();
      checkPort("stale_x4", 0, 5'd4, 1'b1, 32'h0, 4'd5);

      // rename beats same-cycle commit
      setRen(0, 5'd6, 4'd1);
      tick();
      setCmt(0, 5'd6, 4'd1, 32'h66);
      setRen(1, 5'd6, 4'd9);
      tick();
      checkPort("ren_over_cmt_x6", 1, 5'd6, 1'b1, 32'h0, 4'd9);

      // dual rename and dual commit to one register
      setRen(0, 5'd8, 4'd3);
      setRen(1, 5'd8, 4'd4);
      tick();
      checkPort("dual_ren_x8", 2, 5'd8, 1'b1, 32'h0, 4'd4);
      setCmt(0, 5'd8, 4'd4, 32'h81);
      setCmt(1, 5'd8, 4'd4, 32'h82);
      checkPort("dual_byp_x8", 3, 5'd8, 1'b0, 32'h82, 4'd0);
      tick();
      checkPort("dual_cmt_x8", 3, 5'd8, 1'b0, 32'h82, 4'd0);
      setCmt(0, 5'd9, 4'd0, 32'hA);
      setCmt(1, 5'd9, 4'd0, 32'hB);
      tick();
      checkPort("dual_cmt_x9", 0, 5'd9, 1'b0, 32'hB, 4'd0);

      // flush with same-cycle commit and rename
      setRen(0, 5'd1, 4'd1);
      setRen(1, 5'd2, 4'd2);
      tick();
      flush_in = 1'b1;
      setCmt(0, 5'd1, 4'd1, 32'h77);
      setRen(0, 5'd10, 4'd6);
      tick();
      checkPort("flush_x1", 0, 5'd1, 1'b0, 32'h77, 4'd0);
      checkPort("flush_x2", 1, 5'd2, 1'b0, 32'h0, 4'd0);
      checkPort("flush_x10", 2, 5'd10, 1'b0, 32'h0, 4'd0);
      checkPort("flush_x4", 3, 5'd4, 1'b0, 32'h11, 4'd0);
      checkPort("flush_x6", 0, 5'd6, 1'b0, 32'h66, 4'd0);

      // rdy low holds every piece of state
      setRen(0, 5'd12, 4'd5);
      tick();
      rdy_in   = 1'b0;
      flush_in = 1'b1;
      setRen(0, 5'd11, 4'd3);
      setCmt(0, 5'd9, 4'd0, 32'h55);
      tick();
      checkPort("hold_x11", 1, 5'd11, 1'b0, 32'h0, 4'd0);
      checkPort("hold_x12", 2, 5'd12, 1'b1, 32'h0, 4'd5);
      checkPort("hold_x9", 3, 5'd9, 1'b0, 32'hB, 4'd0);

      // x0 is immune to rename and commit
      setRen(0, 5'd0, 4'd7);
      setCmt(0, 5'd0, 4'd7, 32'hFFFF);
      tick();
      checkPort("x0", 0, 5'd0, 1'b0, 32'h0, 4'd0);

      // asynchronous reset mid-run
      setCmt(0, 5'd5, 4'd0, 32'h1234);
      tick();
      setRen(1, 5'd5, 4'd3);
      tick();
      checkPort("pre_rst_x5", 0, 5'd5, 1'b1, 32'h0, 4'd3);
      #1;
      rst_in = 1'b1;
      checkPort("async_rst_x5", 0, 5'd5, 1'b0, 32'h0, 4'd0);
      checkPort("async_rst_x9", 1, 5'd9, 1'b0, 32'h0, 4'd0);
      rst_in = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
